// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the fetch FSM states, the {pc, inst} entry type and the PC step.
package if_pkg;

    typedef enum logic [1:0] {
        BOOT,
        REQ,
        WAIT,
        DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP  = 32'd4;
    localparam logic [31:0] NOP_INST = 32'h0340_0000;

endpackage

// File: rtl/if_fetch_fifo.sv
// Small FIFO of fetched {pc, inst} entries between IF and ID.
// Ports: clk, rst_n, push/din, pop, clear (flush), head (comb), count.
module if_fetch_fifo
    import if_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t din,
    input  logic         pop,
    input  logic         clear,
    output fetch_entry_t head,
    output logic [AW:0]  count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push}
                           - {{AW{1'b0}}, pop};
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push && !clear)
            mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: next-PC mux, single-outstanding IROM fetch, output FIFO to ID.
// Ports: if_clk/if_rst_n, pc/npc, irom_* request/response, redirect, id_*.
module if_fetch_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INST = if_pkg::NOP_INST
) (
    input  logic        if_clk,
    input  logic        if_rst_n,
    input  logic [31:0] pc,
    output logic [31:0] npc,
    output logic        irom_req,
    output logic [31:0] irom_addr,
    input  logic        irom_gnt,
    input  logic        irom_rvalid,
    input  logic [31:0] irom_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst
);

    import if_pkg::fetch_state_e, if_pkg::fetch_entry_t, if_pkg::PC_STEP;
    import if_pkg::BOOT, if_pkg::REQ, if_pkg::WAIT, if_pkg::DRAIN;

    localparam int AW = $clog2(DEPTH);

    fetch_state_e state;
    fetch_state_e state_nx;
    logic [31:0]  req_pc;
    logic [AW:0]  count;
    fetch_entry_t head;
    fetch_entry_t push_entry;
    logic         hs;
    logic         push;
    logic         pop;
    logic         credit;

    assign irom_addr = pc;

    // Redirect hides the FIFO and blocks push; it is cleared at the edge.
    assign id_valid = (count != '0) && !redirect;
    assign pop      = id_valid && id_ready;
    assign push     = (state == WAIT) && irom_rvalid && !redirect;

    // Reserve a slot for the response before issuing, so no overflow.
    assign credit = (int'(count) + int'(push) - int'(pop)) < DEPTH;

    assign irom_req = ((state == REQ) || ((state == WAIT) && irom_rvalid))
                    && !redirect && credit;
    assign hs       = irom_req && irom_gnt;

    assign npc = redirect ? {redirect_pc[31:2], 2'b00}
               : hs       ? pc + PC_STEP
               :            pc;

    assign push_entry = '{pc: req_pc, inst: irom_rdata};

    assign id_pc   = id_valid ? head.pc   : 32'h0;
    assign id_inst = id_valid ? head.inst : NOP_INST;

    always_ff @(posedge if_clk or negedge if_rst_n) begin
        if (!if_rst_n) begin
            state  <= BOOT;
            req_pc <= '0;
        end else begin
            state <= state_nx;
            if (hs)
                req_pc <= pc;
        end
    end

    // DRAIN waits out a response whose request was flushed.
    always_comb begin
        state_nx = state;
        unique case (state)
            BOOT:
                state_nx = REQ;
            REQ:
                if (hs)
                    state_nx = WAIT;
            WAIT:
                if (irom_rvalid)
                    state_nx = hs ? WAIT : REQ;
                else if (redirect)
                    state_nx = DRAIN;
            DRAIN:
                if (irom_rvalid)
                    state_nx = REQ;
            default:
                state_nx = BOOT;
        endcase
    end

    if_fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (if_clk),
        .rst_n (if_rst_n),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .clear (redirect),
        .head  (head),
        .count (count)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit with a queue-based fetch model.
// Bench acts as PC register, IROM (random grant/latency) and decode.
module tb_if_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0340_0000;

    logic        if_clk = 1'b0;
    logic        if_rst_n = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] npc;
    logic        irom_req;
    logic [31:0] irom_addr;
    logic        irom_gnt = 1'b0;
    logic        irom_rvalid = 1'b0;
    logic [31:0] irom_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    always #5 if_clk = ~if_clk;

    if_fetch_unit #(
        .DEPTH    (DEPTH),
        .NOP_INST (NOP)
    ) dut (
        .if_clk      (if_clk),
        .if_rst_n    (if_rst_n),
        .pc          (pc),
        .npc         (npc),
        .irom_req    (irom_req),
        .irom_addr   (irom_addr),
        .irom_gnt    (irom_gnt),
        .irom_rvalid (irom_rvalid),
        .irom_rdata  (irom_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_pc       (id_pc),
        .id_inst     (id_inst)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    int          checks = 0;
    int          failures = 0;
    ent_t        q[$];
    bit          boot;
    bit          outst;
    bit          flushed;
    logic [31:0] out_addr;
    int          lat;
    logic [31:0] pc_nx = '0;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check at +1, update model.
    task automatic step(input bit rdr, input logic [31:0] rpc,
                        input bit rdy, input bit gnt,
                        input bit stray, input int nlat);
        bit          rv;
        bit          real_rv;
        bit          push_m;
        bit          pop_m;
        bit          exp_v;
        bit          exp_req;
        bit          hs;
        int          occ;
        logic [31:0] exp_npc;
        @(negedge if_clk);
        if_rst_n    = 1'b1;
        pc          = pc_nx;
        rv          = outst ? (lat == 0) : stray;
        redirect    = rdr;
        redirect_pc = rpc;
        id_ready    = rdy;
        irom_gnt    = gnt;
        irom_rvalid = rv;
        irom_rdata  = outst ? rom(out_addr) : $urandom;
        #1;
        real_rv = outst && rv;
        push_m  = real_rv && !flushed && !rdr;
        exp_v   = !rdr && (q.size() > 0);
        pop_m   = exp_v && rdy;
        occ     = q.size() + int'(push_m) - int'(pop_m);
        exp_req = !boot && !rdr && occ < DEPTH
                && (!outst || (real_rv && !flushed));
        chk("irom_req", {31'b0, irom_req}, {31'b0, exp_req});
        chk("irom_addr", irom_addr, pc);
        chk("id_valid", {31'b0, id_valid}, {31'b0, exp_v});
        if (exp_v) begin
            chk("id_pc", id_pc, q[0].pc);
            chk("id_inst", id_inst, q[0].inst);
        end else begin
            chk("id_inst_nop", id_inst, NOP);
        end
        hs      = irom_req && gnt;
        exp_npc = rdr ? {rpc[31:2], 2'b00} : hs ? pc + 32'd4 : pc;
        chk("npc", npc, exp_npc);
        if (pop_m)
            void'(q.pop_front());
        if (push_m)
            q.push_back('{out_addr, rom(out_addr)});
        if (rdr)
            q.delete();
        if (outst) begin
            if (rv) begin
                outst = 1'b0;
            end else begin
                lat--;
                if (rdr)
                    flushed = 1'b1;
            end
        end
        if (hs) begin
            outst    = 1'b1;
            out_addr = pc;
            lat      = nlat;
            flushed  = 1'b0;
        end
        boot  = 1'b0;
        pc_nx = exp_npc;
    endtask

    // Reset asserted mid-cycle; released at the next step's negedge.
    task automatic do_reset();
        @(negedge if_clk);
        if_rst_n    = 1'b0;
        redirect    = 1'b0;
        irom_rvalid = 1'b0;
        irom_gnt    = 1'b0;
        pc          = pc_nx;
        #1;
        chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_irom_req", {31'b0, irom_req}, 32'd0);
        chk("rst_id_inst", id_inst, NOP);
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_npc", npc, pc);
        q.delete();
        outst   = 1'b0;
        flushed = 1'b0;
        boot    = 1'b1;
        pc_nx   = '0;
    endtask

    initial begin
        // Streaming fetch, stray rvalid in BOOT.
        do_reset();
        step(0, 0, 1, 1, 1, 0);
        repeat (10) step(0, 0, 1, 1, 0, 0);

        // Back-pressure fills the FIFO, then one pop.
        do_reset();
        step(0, 0, 0, 1, 0, 0);
        repeat (6) step(0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        repeat (3) step(0, 0, 0, 1, 0, 0);
        repeat (4) step(0, 0, 1, 1, 0, 0);

        // Redirect while a slow response is outstanding.
        do_reset();
        step(0, 0, 1, 1, 0, 0);
        repeat (8) step(0, 0, 1, 1, 0, 0);
        step(0, 0, 1, 1, 0, 2);
        step(1, 32'h1C00_0040, 1, 1, 0, 0);
        repeat (6) step(0, 0, 1, 1, 0, 0);

        // Misaligned redirect with a full FIFO.
        repeat (5) step(0, 0, 0, 1, 0, 0);
        step(1, 32'h1C00_0003, 0, 1, 0, 0);
        repeat (4) step(0, 0, 1, 1, 0, 0);

        // PC wrap at the top of the address space.
        step(1, 32'hFFFF_FFFF, 1, 1, 0, 0);
        repeat (5) step(0, 0, 1, 1, 0, 0);

        // Reset mid-WAIT with one entry held.
        step(0, 0, 0, 1, 0, 3);
        step(0, 0, 0, 1, 0, 3);
        do_reset();
        step(0, 0, 1, 1, 1, 0);
        repeat (6) step(0, 0, 1, 1, 0, 0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 11) == 0),
                 $urandom,
                 1'($urandom),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom),
                 int'($urandom_range(0, 3)));
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
